matrix_keypad_scanner: RTL and testbench

MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

---
 rtl/keypad_pkg.sv | 17 +
 rtl/sync_fifo.sv | 73 +++++++
 rtl/matrix_keypad_scanner.sv | 192 +++++++++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
//   state_e    : scanner FSM states
//   code_width : bits needed to number nkeys keys (minimum 1)
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StPressDb,
    StHeld,
    StRelDb
  } state_e;

  function automatic int unsigned code_width(input int unsigned nkeys);
    return (nkeys > 1) ? $clog2(nkeys) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (empties the queue)
//   push_i  : write wdata_i; ignored when full unless a pop happens in the same cycle
//   wdata_i : data to write
//   pop_i   : remove head; ignored when empty
//   full_o  : DEPTH entries held
//   empty_o : no entries held
//   head_o  : oldest entry, meaningful only while !empty_o
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot, so a push into a full queue is accepted alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through a valid head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Matrix keypad scanner: drives one-cold columns, debounces presses and releases on the
// active-low rows, and queues the code of each single-key press.
// Ports:
//   clock     : sole clock
//   reset     : synchronous active-high reset
//   row       : asynchronous keypad rows, active-low
//   col       : column drive, exactly one bit low
//   key_valid : queue head valid
//   key_code  : queue head code (column*NROWS + row), 0 while the queue is empty
//   key_ready : consumer accepts head
//   multi_key : one-cycle strobe, debounced press had several rows low (not queued)
//   overflow  : sticky, a press was dropped because the queue was full
//   key_held  : a debounced key is down (held or release being debounced)
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned NROWS      = 4,
  parameter int unsigned NCOLS      = 4,
  parameter int unsigned SCAN_DIV   = 9,
  parameter int unsigned DEBOUNCE   = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CODE_W    = code_width(NROWS * NCOLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NROWS-1:0]  row,
  output logic [NCOLS-1:0]  col,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              multi_key,
  output logic              overflow,
  output logic              key_held
);

  localparam int unsigned N_W     = $clog2(NCOLS);
  localparam int unsigned ROW_W   = $clog2(NROWS);
  localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE + 1);
  localparam logic [NROWS-1:0] ALL_ONES = '1;

  // Two-flop synchroniser; rs_q is the only view of the rows used below.
  logic [NROWS-1:0]   row_meta_q, rs_q;

  state_e             state_q, state_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0]    cnt_q, cnt_d;
  logic [NROWS-1:0]   snap_q, snap_d;
  logic               push_q, push_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               multi_q, multi_d;
  logic               overflow_q, overflow_d;

  logic [NROWS-1:0]   snap_low;
  logic               single_low;
  logic [ROW_W-1:0]   low_idx;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [CODE_W-1:0]  fifo_head;

  // Decode the latched snapshot: is exactly one row low, and which one.
  always_comb begin
    snap_low   = ~snap_q;
    single_low = ($countones(snap_low) == 1);
    low_idx    = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (snap_low[r]) low_idx = ROW_W'(r);
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    push_d  = 1'b0;
    code_d  = code_q;
    multi_d = 1'b0;
    unique case (state_q)
      StScan: begin
        if (rs_q != ALL_ONES) begin
          // Column freezes while the press is qualified.
          state_d = StPressDb;
          snap_d  = rs_q;
          cnt_d   = '0;
          dwell_d = '0;
        end else if (dwell_q == DWELL_W'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          n_d     = (n_q == N_W'(NCOLS - 1)) ? '0 : n_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StPressDb: begin
        if (rs_q != snap_q) begin
          state_d = StScan;
          dwell_d = '0;
        end else if (cnt_q == DB_W'(DEBOUNCE - 1)) begin
          // This increment reaches DEBOUNCE: the press is evaluated now and the
          // push lands in the queue on the following edge.
          state_d = StHeld;
          cnt_d   = '0;
          if (single_low) begin
            push_d = 1'b1;
            code_d = CODE_W'(int'(n_q) * int'(NROWS) + int'(low_idx));
          end else begin
            multi_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (rs_q == ALL_ONES) begin
          state_d = StRelDb;
          cnt_d   = '0;
        end
      end
      StRelDb: begin
        if (rs_q != ALL_ONES) begin
          state_d = StHeld;
        end else if (cnt_q == DB_W'(DEBOUNCE - 1)) begin
          state_d = StScan;
          dwell_d = '0;
          n_d     = (n_q == N_W'(NCOLS - 1)) ? '0 : n_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign fifo_pop   = key_valid & key_ready;
  // A push into a full queue survives only if the head leaves in the same cycle.
  assign overflow_d = overflow_q | (push_q & fifo_full & ~fifo_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta_q <= '1;
      rs_q       <= '1;
      state_q    <= StScan;
      n_q        <= '0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      snap_q     <= '1;
      push_q     <= 1'b0;
      code_q     <= '0;
      multi_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      row_meta_q <= row;
      rs_q       <= row_meta_q;
      state_q    <= state_d;
      n_q        <= n_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      push_q     <= push_d;
      code_q     <= code_d;
      multi_q    <= multi_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push_q),
    .wdata_i (code_q),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    col        = '1;
    col[n_q]   = 1'b0;
  end

  assign key_valid = ~fifo_empty;
  assign key_code  = fifo_empty ? '0 : fifo_head;
  assign multi_key = multi_q;
  assign overflow  = overflow_q;
  assign key_held  = (state_q == StHeld) || (state_q == StRelDb);

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
module tb_matrix_keypad_scanner;

  localparam int NROWS      = 4;
  localparam int NCOLS      = 4;
  localparam int SCAN_DIV   = 9;
  localparam int DEBOUNCE   = 5;
  localparam int FIFO_DEPTH = 4;
  localparam logic [NROWS-1:0] ONES = '1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row = 4'hF;
  logic       key_ready = 1'b0;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       multi_key, overflow, key_held;

  int n_checks = 0;
  int n_errors = 0;

  matrix_keypad_scanner #(
    .NROWS      (NROWS),
    .NCOLS      (NCOLS),
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE   (DEBOUNCE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .multi_key (multi_key),
    .overflow  (overflow),
    .key_held  (key_held)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference. Scan position is one time index t over a full sweep of
  // NCOLS*SCAN_DIV cycles (column = t / SCAN_DIV); mode 0 scanning, 1 qualifying a
  // press, 2 key down, 3 qualifying a release; the queue is a plain SV queue.
  int               m_t, m_mode, m_cnt, m_pend_code;
  bit               m_init = 0;
  bit               m_pend, m_multi, m_ovf;
  logic [NROWS-1:0] m_s1, m_s2, m_snap;
  int               mq[$];

  always @(posedge clock) begin : model
    logic [NROWS-1:0] rsv;
    int lows, ridx;
    if (reset) begin
      m_init = 1; m_t = 0; m_mode = 0; m_cnt = 0;
      m_s1 = ONES; m_s2 = ONES; m_snap = ONES;
      mq.delete(); m_pend = 0; m_pend_code = 0; m_multi = 0; m_ovf = 0;
    end else if (m_init) begin
      if (key_ready && mq.size() > 0) void'(mq.pop_front());
      if (m_pend) begin
        if (mq.size() < FIFO_DEPTH) mq.push_back(m_pend_code);
        else m_ovf = 1;
      end
      m_pend  = 0;
      m_multi = 0;
      rsv = m_s2;
      case (m_mode)
        0: if (rsv != ONES) begin
             m_mode = 1; m_snap = rsv; m_cnt = 0;
           end else begin
             m_t = (m_t + 1) % (NCOLS * SCAN_DIV);
           end
        1: if (rsv != m_snap) begin
             m_mode = 0; m_t = (m_t / SCAN_DIV) * SCAN_DIV;
           end else begin
             m_cnt++;
             if (m_cnt == DEBOUNCE) begin
               m_mode = 2;
               lows = 0; ridx = 0;
               for (int r = 0; r < NROWS; r++) if (!rsv[r]) begin lows++; ridx = r; end
               if (lows == 1) begin
                 m_pend = 1; m_pend_code = (m_t / SCAN_DIV) * NROWS + ridx;
               end else begin
                 m_multi = 1;
               end
             end
           end
        2: if (rsv == ONES) begin m_mode = 3; m_cnt = 0; end
        default: if (rsv != ONES) begin
             m_mode = 2;
           end else begin
             m_cnt++;
             if (m_cnt == DEBOUNCE) begin
               m_mode = 0; m_t = ((m_t / SCAN_DIV + 1) % NCOLS) * SCAN_DIV;
             end
           end
      endcase
      m_s2 = m_s1;
      m_s1 = row;
    end
  end

  always @(negedge clock) begin : compare
    logic [3:0] exp_col;
    if (m_init) begin
      exp_col = 4'hF;
      exp_col[m_t / SCAN_DIV] = 1'b0;
      chk("cyc_col", int'(col), int'(exp_col));
      chk("cyc_key_valid", int'(key_valid), (mq.size() > 0) ? 1 : 0);
      chk("cyc_key_code", int'(key_code), (mq.size() > 0) ? mq[0] : 0);
      chk("cyc_multi_key", int'(multi_key), int'(m_multi));
      chk("cyc_overflow", int'(overflow), int'(m_ovf));
      chk("cyc_key_held", int'(key_held), (m_mode >= 2) ? 1 : 0);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Waits for the target column to be freshly entered (dwell start).
  task automatic wait_col(input logic [3:0] target);
    int k;
    k = 0;
    while (col == target && k < 80) begin tick(); k++; end
    while (col != target && k < 160) begin tick(); k++; end
    if (col != target) chk("wait_col_timeout", int'(col), int'(target));
  endtask

  logic [3:0] col_tbl [4];
  logic [3:0] key_col [5];
  logic [3:0] key_row [5];
  int         key_exp [4];

  initial begin
    col_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    key_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    key_row = '{4'b1110, 4'b0111, 4'b1101, 4'b1011, 4'b0111};
    key_exp = '{0, 7, 9, 14};

    // Reset and idle scan sequence.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_key_code", int'(key_code), 0);
    chk("rst_multi", int'(multi_key), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_key_held", int'(key_held), 0);
    for (int j = 0; j < 40; j++) begin
      chk("idle_col", int'(col), int'(col_tbl[(j / SCAN_DIV) % NCOLS]));
      tick();
    end

    // Clean press of row 2 in column 2: code 10 after 9 cycles.
    wait_col(4'b1011);
    row = 4'b1011;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k < 9) chk("lat_valid_early", int'(key_valid), 0);
    end
    chk("lat_valid", int'(key_valid), 1);
    chk("lat_code", int'(key_code), 10);
    chk("lat_held", int'(key_held), 1);
    repeat (3) tick();
    row = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) chk("rel_col_before", int'(col), 4'b1011);
      if (k == 8) chk("rel_col_after", int'(col), 4'b0111);
      if (k == 8) chk("rel_held_clear", int'(key_held), 0);
    end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("pop_empty", int'(key_valid), 0);

    // Two rows low in column 0.
    wait_col(4'b1110);
    row = 4'b0101;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7) chk("multi_early", int'(multi_key), 0);
      if (k == 8) chk("multi_pulse", int'(multi_key), 1);
      if (k == 9) chk("multi_once", int'(multi_key), 0);
    end
    chk("multi_no_push", int'(key_valid), 0);
    row = 4'hF;
    repeat (12) tick();

    // Bouncy press, row 0 in column 1.
    wait_col(4'b1101);
    for (int i = 0; i < 20; i++) begin
      row = (((i / 3) % 2) == 0) ? 4'b1110 : 4'b1111;
      tick();
      chk("bounce_no_push", int'(key_valid), 0);
    end
    row = 4'b1110;
    repeat (12) tick();
    chk("bounce_valid", int'(key_valid), 1);
    chk("bounce_code", int'(key_code), 4);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("bounce_single_push", int'(key_valid), 0);
    row = 4'hF;
    repeat (12) tick();

    // Five presses into a four-deep queue.
    for (int p = 0; p < 5; p++) begin
      wait_col(key_col[p]);
      row = key_row[p];
      repeat (12) tick();
      row = 4'hF;
      repeat (10) tick();
      if (p == 3) chk("ovf_not_yet", int'(overflow), 0);
    end
    chk("ovf_set", int'(overflow), 1);
    key_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("drain_valid", int'(key_valid), 1);
      chk("drain_code", int'(key_code), key_exp[j]);
      tick();
    end
    chk("drain_empty", int'(key_valid), 0);
    key_ready = 1'b0;
    chk("ovf_sticky", int'(overflow), 1);

    // Reset while qualifying a press.
    wait_col(4'b1110);
    row = 4'b1101;
    repeat (5) tick();
    chk("pdb_not_held", int'(key_held), 0);
    reset = 1'b1;
    row = 4'hF;
    tick();
    reset = 1'b0;
    chk("mid_rst_col", int'(col), 4'b1110);
    chk("mid_rst_valid", int'(key_valid), 0);
    chk("mid_rst_code", int'(key_code), 0);
    chk("mid_rst_multi", int'(multi_key), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_held", int'(key_held), 0);
    repeat (15) tick();
    chk("mid_rst_no_push", int'(key_valid), 0);

    // Randomised episodes, checked every cycle by the model.
    for (int ep = 0; ep < 90; ep++) begin
      int kind, len, r;
      logic [3:0] pat;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 16);
      r    = $urandom_range(0, 3);
      if (kind < 5) pat = ~(4'b0001 << r);
      else if (kind < 7) pat = 4'($urandom);
      else pat = 4'hF;
      if ($urandom_range(0, 29) == 0) reset = 1'b1;
      for (int k = 0; k < len; k++) begin
        row = (kind == 9 && (k % 2) == 1) ? 4'hF : pat;
        if (kind == 9 && (k % 2) == 0) row = 4'b1011;
        key_ready = ($urandom_range(0, 2) == 0);
        tick();
        reset = 1'b0;
      end
    end

    row = 4'hF;
    key_ready = 1'b1;
    repeat (30) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
